// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the multi-cycle
// controller (master) and the two memory ports (slave).
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory access and
// write-back sequencing with memory timeouts and a retired-instruction count.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [6:0]                opcode,
    input  logic                      branch_taken,
    multicycle_ctrl_if.master         mem,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic [1:0]                pc_sel,
    output logic                      rf_we,
    output logic [1:0]                wb_sel,
    output logic                      alu_a_pc,
    output logic                      alu_b_imm,
    output logic [2:0]                state,
    output logic                      busy,
    output logic                      illegal,
    output logic                      fault,
    output logic [31:0]               retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_next;
    logic [6:0]  op_q;
    logic [7:0]  wait_cnt;
    logic        retire;
    logic        set_illegal;
    logic        set_fault;
    logic        opcode_valid;
    logic        op_a_pc;
    logic        op_b_imm;
    logic        timeout_hit;

    always_comb begin
        opcode_valid = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_L, OP_S, OP_B,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: opcode_valid = 1'b1;
            default:                           opcode_valid = 1'b0;
        endcase
    end

    assign op_a_pc     = (op_q == OP_AUIPC) || (op_q == OP_JAL);
    assign op_b_imm    = (op_q == OP_I) || (op_q == OP_L) || (op_q == OP_S) ||
                         (op_q == OP_AUIPC) || (op_q == OP_JALR);
    assign timeout_hit = (wait_cnt == TO_LAST);
    assign state       = state_q;
    assign busy        = (state_q != IDLE) && (state_q != HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Ack on the final permitted cycle is checked before the timeout, so it wins.
    always_comb begin
        state_next    = state_q;
        mem.imem_req  = 1'b0;
        mem.dmem_req  = 1'b0;
        mem.dmem_we   = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;
        rf_we         = 1'b0;
        wb_sel        = 2'd0;
        alu_a_pc      = 1'b0;
        alu_b_imm     = 1'b0;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_fault     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end else if (timeout_hit) begin
                    set_fault  = 1'b1;
                    state_next = HALT;
                end
            end
            DECODE: begin
                if (!opcode_valid) begin
                    set_illegal = 1'b1;
                    state_next  = HALT;
                end else begin
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                alu_a_pc  = op_a_pc;
                alu_b_imm = op_b_imm;
                if (op_q == OP_B) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                    retire = 1'b1;
                end else if ((op_q == OP_L) || (op_q == OP_S)) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (op_q == OP_S);
                alu_b_imm    = 1'b1;
                if (mem.dmem_ack) begin
                    if (op_q == OP_S) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_next = WB;
                    end
                end else if (timeout_hit) begin
                    set_fault  = 1'b1;
                    state_next = HALT;
                end
            end
            WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                alu_a_pc  = op_a_pc;
                alu_b_imm = op_b_imm;
                retire    = 1'b1;
                if (op_q == OP_L)                              wb_sel = 2'd1;
                else if ((op_q == OP_JAL) || (op_q == OP_JALR)) wb_sel = 2'd2;
                else if (op_q == OP_LUI)                       wb_sel = 2'd3;
                if (op_q == OP_JAL)       pc_sel = 2'd1;
                else if (op_q == OP_JALR) pc_sel = 2'd2;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (retire) state_next = start ? FETCH : IDLE;
    end

    // Any state change restarts the wait count, covering MEM->FETCH on a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state_q) begin
            wait_cnt <= '0;
        end else if (((state_q == FETCH) && !mem.imem_ack) ||
                     ((state_q == MEM) && !mem.dmem_ack)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            illegal <= 1'b0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            if (state_q == DECODE) op_q <= opcode;
            if (set_illegal)       illegal <= 1'b1;
            if (set_fault)         fault <= 1'b1;
            if (retire)            retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: instruction classes,
// memory waits, timeout/illegal halts, counter wrap and async reset.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic [2:0]  state;
    logic        busy;
    logic        illegal;
    logic        fault;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if mem ();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem          (mem),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_pc     (alu_a_pc),
        .alu_b_imm    (alu_b_imm),
        .state        (state),
        .busy         (busy),
        .illegal      (illegal),
        .fault        (fault),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [6:0] opc,
                                 input logic bt, input logic ia, input logic da);
        start         = st;
        opcode        = opc;
        branch_taken  = bt;
        mem.imem_ack  = ia;
        mem.dmem_ack  = da;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called in the first FETCH cycle: ack at once, then step through DECODE.
    task automatic fetchDecode(input logic st, input logic [6:0] opc);
        applyStimulus(st, opc, 1'b0, 1'b1, 1'b0);
        checkOutput("fetch_ir_we", ir_we, 1);
        tick();
        applyStimulus(st, opc, 1'b0, 1'b0, 1'b0);
        checkOutput("decode_state", state, 2);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_retired", retired, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_imem_req", mem.imem_req, 0);
        rst = 1'b0;

        $display("[TB] R-type with imem ack on third fetch cycle");
        applyStimulus(1'b1, OP_R, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("r_fetch1", state, 1);
        checkOutput("r_imem_req", mem.imem_req, 1);
        checkOutput("r_ir_we_noack", ir_we, 0);
        tick();
        checkOutput("r_fetch2", state, 1);
        tick();
        checkOutput("r_fetch3", state, 1);
        fetchDecode(1'b1, OP_R);
        checkOutput("r_exec", state, 3);
        checkOutput("r_exec_rf_we", rf_we, 0);
        checkOutput("r_exec_pc_we", pc_we, 0);
        tick();
        checkOutput("r_wb", state, 5);
        checkOutput("r_wb_rf_we", rf_we, 1);
        checkOutput("r_wb_sel", wb_sel, 0);
        checkOutput("r_wb_pc_we", pc_we, 1);
        checkOutput("r_wb_pc_sel", pc_sel, 0);
        checkOutput("r_wb_alu_b", alu_b_imm, 0);
        tick();
        checkOutput("r_next_fetch", state, 1);
        checkOutput("r_retired", retired, 1);
        checkOutput("r_rf_we_off", rf_we, 0);

        $display("[TB] LW with dmem ack on fourth MEM cycle");
        fetchDecode(1'b1, OP_L);
        checkOutput("lw_exec_b_imm", alu_b_imm, 1);
        tick();
        checkOutput("lw_mem", state, 4);
        checkOutput("lw_dmem_req1", mem.dmem_req, 1);
        checkOutput("lw_dmem_we", mem.dmem_we, 0);
        checkOutput("lw_mem_b_imm", alu_b_imm, 1);
        tick();
        checkOutput("lw_dmem_req2", mem.dmem_req, 1);
        tick();
        checkOutput("lw_dmem_req3", mem.dmem_req, 1);
        tick();
        applyStimulus(1'b1, OP_L, 1'b0, 1'b0, 1'b1);
        checkOutput("lw_dmem_req4", mem.dmem_req, 1);
        checkOutput("lw_mem_rf_we", rf_we, 0);
        tick();
        applyStimulus(1'b1, OP_L, 1'b0, 1'b0, 1'b0);
        checkOutput("lw_wb", state, 5);
        checkOutput("lw_wb_sel", wb_sel, 1);
        checkOutput("lw_wb_rf_we", rf_we, 1);
        checkOutput("lw_wb_dmem_req", mem.dmem_req, 0);
        tick();
        checkOutput("lw_retired", retired, 2);

        $display("[TB] SW");
        fetchDecode(1'b1, OP_S);
        checkOutput("sw_exec_rf_we", rf_we, 0);
        tick();
        checkOutput("sw_mem", state, 4);
        checkOutput("sw_dmem_we", mem.dmem_we, 1);
        applyStimulus(1'b1, OP_S, 1'b0, 1'b0, 1'b1);
        checkOutput("sw_pc_we", pc_we, 1);
        checkOutput("sw_pc_sel", pc_sel, 0);
        checkOutput("sw_rf_we", rf_we, 0);
        tick();
        applyStimulus(1'b1, OP_S, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_next_fetch", state, 1);
        checkOutput("sw_retired", retired, 3);

        $display("[TB] BEQ taken and not taken");
        fetchDecode(1'b1, OP_B);
        applyStimulus(1'b1, OP_B, 1'b1, 1'b0, 1'b0);
        checkOutput("beq_t_pc_we", pc_we, 1);
        checkOutput("beq_t_pc_sel", pc_sel, 1);
        checkOutput("beq_t_rf_we", rf_we, 0);
        tick();
        checkOutput("beq_t_next_fetch", state, 1);
        checkOutput("beq_t_retired", retired, 4);
        fetchDecode(1'b1, OP_B);
        applyStimulus(1'b1, OP_B, 1'b0, 1'b0, 1'b0);
        checkOutput("beq_nt_pc_we", pc_we, 1);
        checkOutput("beq_nt_pc_sel", pc_sel, 0);
        tick();
        checkOutput("beq_nt_next_fetch", state, 1);
        checkOutput("beq_nt_retired", retired, 5);

        $display("[TB] JAL, JALR, LUI");
        fetchDecode(1'b1, OP_JAL);
        checkOutput("jal_a_pc", alu_a_pc, 1);
        checkOutput("jal_b_imm", alu_b_imm, 0);
        tick();
        checkOutput("jal_wb", state, 5);
        checkOutput("jal_wb_sel", wb_sel, 2);
        checkOutput("jal_pc_sel", pc_sel, 1);
        checkOutput("jal_wb_a_pc", alu_a_pc, 1);
        tick();
        checkOutput("jal_retired", retired, 6);
        fetchDecode(1'b1, OP_JALR);
        checkOutput("jalr_a_pc", alu_a_pc, 0);
        checkOutput("jalr_b_imm", alu_b_imm, 1);
        tick();
        checkOutput("jalr_wb_sel", wb_sel, 2);
        checkOutput("jalr_pc_sel", pc_sel, 2);
        tick();
        checkOutput("jalr_retired", retired, 7);
        fetchDecode(1'b1, OP_LUI);
        applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lui_exec_latched_op", state, 3);
        tick();
        checkOutput("lui_wb", state, 5);
        checkOutput("lui_wb_sel", wb_sel, 3);
        checkOutput("lui_pc_sel", pc_sel, 0);
        checkOutput("lui_rf_we", rf_we, 1);
        tick();
        checkOutput("lui_retired", retired, 8);

        $display("[TB] LW, start dropped in MEM, ack on last permitted cycle");
        fetchDecode(1'b1, OP_L);
        tick();
        applyStimulus(1'b0, OP_L, 1'b0, 1'b0, 1'b0);
        repeat (14) tick();
        checkOutput("lw15_mem", state, 4);
        checkOutput("lw15_dmem_req", mem.dmem_req, 1);
        applyStimulus(1'b0, OP_L, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, OP_L, 1'b0, 1'b0, 1'b0);
        checkOutput("lw15_ack_wins", state, 5);
        checkOutput("lw15_no_fault", fault, 0);
        tick();
        checkOutput("lw15_idle", state, 0);
        checkOutput("lw15_retired", retired, 9);
        checkOutput("lw15_busy", busy, 0);

        $display("[TB] retired counter wrap");
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        checkOutput("wrap_preload", retired, 32'hFFFF_FFFF);
        applyStimulus(1'b1, OP_R, 1'b0, 1'b0, 1'b0);
        tick();
        fetchDecode(1'b1, OP_R);
        tick();
        tick();
        checkOutput("wrap_state", state, 1);
        checkOutput("wrap_retired", retired, 0);

        $display("[TB] imem timeout");
        applyStimulus(1'b1, OP_R, 1'b0, 1'b0, 1'b0);
        repeat (14) tick();
        checkOutput("to_last_fetch", state, 1);
        checkOutput("to_last_req", mem.imem_req, 1);
        tick();
        checkOutput("to_halt", state, 6);
        checkOutput("to_fault", fault, 1);
        checkOutput("to_req_drop", mem.imem_req, 0);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_illegal", illegal, 0);
        repeat (3) tick();
        checkOutput("to_halt_sticky", state, 6);
        rst = 1'b1;
        #1;
        checkOutput("to_rst_state", state, 0);
        checkOutput("to_rst_fault", fault, 0);
        #2;
        rst = 1'b0;

        $display("[TB] illegal opcode");
        applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        fetchDecode(1'b1, 7'd0);
        checkOutput("ill_halt", state, 6);
        checkOutput("ill_flag", illegal, 1);
        checkOutput("ill_busy", busy, 0);
        checkOutput("ill_fault", fault, 0);
        rst = 1'b1;
        #2;
        rst = 1'b0;

        $display("[TB] reset asserted during MEM");
        applyStimulus(1'b1, OP_S, 1'b0, 1'b0, 1'b0);
        tick();
        fetchDecode(1'b1, OP_S);
        tick();
        checkOutput("rstmem_req_before", mem.dmem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmem_req_drop", mem.dmem_req, 0);
        checkOutput("rstmem_state", state, 0);
        #2;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
